// File: rtl/mem_arbiter_if.sv
// Handshake bundle between the memory arbiter, its two requesters and the memory.
// The master modport is the arbiter's view; slave is the environment's view.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 18
);
  logic                  FETCH_REQ;
  logic [ADDR_WIDTH-1:0] FETCH_ADDR;
  logic                  FETCH_GNT;
  logic                  FETCH_VALID;
  logic [DATA_WIDTH-1:0] FETCH_DATA;

  logic                  LS_REQ;
  logic                  LS_WE;
  logic [ADDR_WIDTH-1:0] LS_ADDR;
  logic [DATA_WIDTH-1:0] LS_WDATA;
  logic                  LS_GNT;
  logic                  LS_VALID;
  logic [DATA_WIDTH-1:0] LS_RDATA;

  logic                  MEM_EN;
  logic                  MEM_WE;
  logic [ADDR_WIDTH-1:0] MEM_ADDR;
  logic [DATA_WIDTH-1:0] MEM_WDATA;
  logic [DATA_WIDTH-1:0] MEM_RDATA;

  logic                  BUSY;

  modport master (
    input  FETCH_REQ, FETCH_ADDR, LS_REQ, LS_WE, LS_ADDR, LS_WDATA, MEM_RDATA,
    output FETCH_GNT, FETCH_VALID, FETCH_DATA, LS_GNT, LS_VALID, LS_RDATA,
    output MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, BUSY
  );

  modport slave (
    output FETCH_REQ, FETCH_ADDR, LS_REQ, LS_WE, LS_ADDR, LS_WDATA, MEM_RDATA,
    input  FETCH_GNT, FETCH_VALID, FETCH_DATA, LS_GNT, LS_VALID, LS_RDATA,
    input  MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, BUSY
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares a fixed-latency single-port memory between instruction fetch and load/store.
// Load/store wins arbitration until it has won MAX_DATA_STREAK times while fetch waited.
module mem_arbiter #(
  parameter int ADDR_WIDTH      = 10,
  parameter int DATA_WIDTH      = 18,
  parameter int MEM_LATENCY     = 1,
  parameter int MAX_DATA_STREAK = 2
) (
  input logic           CPU_CLOCK,
  input logic           RESET,
  mem_arbiter_if.master bus
);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [CW-1:0] LAT        = CW'(MEM_LATENCY);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;
  typedef enum logic {OWN_FETCH, OWN_LS} owner_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } issue_t;

  state_t                state, state_nxt;
  owner_t                owner;
  issue_t                iss;
  logic [CW-1:0]         wait_cnt;
  logic [SW-1:0]         streak;
  logic [DATA_WIDTH-1:0] fetch_data, ls_rdata;
  logic                  grant, fetch_wins, last_wait;

  always_ff @(posedge CPU_CLOCK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    grant      = ((state == S_IDLE) || (state == S_RESPOND)) && (bus.FETCH_REQ || bus.LS_REQ);
    fetch_wins = bus.FETCH_REQ && (!bus.LS_REQ || streak == STREAK_MAX);
    last_wait  = (state == S_WAIT) && (wait_cnt == CW'(1));
    state_nxt  = state;
    case (state)
      S_IDLE, S_RESPOND: state_nxt = grant ? S_ISSUE : S_IDLE;
      S_ISSUE:           state_nxt = S_WAIT;
      S_WAIT:            if (last_wait) state_nxt = S_RESPOND;
      default:           state_nxt = S_IDLE;
    endcase

    // Strobes decode from state alone so an async reset clears them at once.
    bus.MEM_EN      = (state == S_ISSUE);
    bus.MEM_WE      = (state == S_ISSUE) && iss.we;
    bus.MEM_ADDR    = iss.addr;
    bus.MEM_WDATA   = iss.wdata;
    bus.FETCH_GNT   = (state == S_ISSUE)   && (owner == OWN_FETCH);
    bus.LS_GNT      = (state == S_ISSUE)   && (owner == OWN_LS);
    bus.FETCH_VALID = (state == S_RESPOND) && (owner == OWN_FETCH);
    bus.LS_VALID    = (state == S_RESPOND) && (owner == OWN_LS);
    bus.FETCH_DATA  = fetch_data;
    bus.LS_RDATA    = ls_rdata;
    bus.BUSY        = (state != S_IDLE);
  end

  always_ff @(posedge CPU_CLOCK or posedge RESET) begin
    if (RESET) begin
      owner      <= OWN_FETCH;
      iss        <= '0;
      wait_cnt   <= '0;
      streak     <= '0;
      fetch_data <= '0;
      ls_rdata   <= '0;
    end else begin
      if (grant) begin
        owner    <= fetch_wins ? OWN_FETCH : OWN_LS;
        iss.we   <= fetch_wins ? 1'b0 : bus.LS_WE;
        iss.addr <= fetch_wins ? bus.FETCH_ADDR : bus.LS_ADDR;
        if (!fetch_wins) iss.wdata <= bus.LS_WDATA;
        // Streak only grows while fetch is actually being held off.
        if (fetch_wins || !bus.FETCH_REQ) streak <= '0;
        else if (streak != STREAK_MAX)    streak <= streak + SW'(1);
      end
      if (state == S_ISSUE)     wait_cnt <= LAT;
      else if (state == S_WAIT) wait_cnt <= wait_cnt - CW'(1);
      if (last_wait && !iss.we) begin
        if (owner == OWN_FETCH) fetch_data <= bus.MEM_RDATA;
        else                    ls_rdata   <= bus.MEM_RDATA;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run scored against
// a transaction-level model (grant order, latency, addresses, returned data).
module tb_mem_arbiter;
  localparam int AW   = 10;
  localparam int DW   = 18;
  localparam int MAXS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1), .MAX_DATA_STREAK(MAXS))
    u_dut (.CPU_CLOCK(clk), .RESET(rst), .bus(bus0));
  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(3), .MAX_DATA_STREAK(MAXS))
    u_dut3 (.CPU_CLOCK(clk), .RESET(rst), .bus(bus1));

  // Latency-1 memory; read data is inverted garbage outside its one valid cycle.
  logic [DW-1:0] mem0 [0:1023];
  logic          rd0_vld = 1'b0;
  logic [DW-1:0] rd0_q   = '0;
  logic          bd_en   = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  always @(posedge clk) begin
    if (bd_en) mem0[bd_addr] <= bd_data;
    if (bus0.MEM_EN && bus0.MEM_WE) mem0[bus0.MEM_ADDR] <= bus0.MEM_WDATA;
    rd0_vld <= bus0.MEM_EN;
    rd0_q   <= mem0[bus0.MEM_ADDR];
  end
  assign bus0.MEM_RDATA = rd0_vld ? rd0_q : ~rd0_q;

  // Latency-3 read-only memory with a fixed content pattern.
  function automatic logic [DW-1:0] pat1(input logic [AW-1:0] a);
    return {a[7:0], a} ^ 18'h2A5A5;
  endfunction
  logic [2:0]    rd1_vld = '0;
  logic [AW-1:0] rd1_a [0:2];
  always @(posedge clk) begin
    rd1_vld  <= {rd1_vld[1:0], bus1.MEM_EN};
    rd1_a[0] <= bus1.MEM_ADDR;
    rd1_a[1] <= rd1_a[0];
    rd1_a[2] <= rd1_a[1];
  end
  assign bus1.MEM_RDATA = rd1_vld[2] ? pat1(rd1_a[2]) : '0;

  task automatic idle_inputs();
    bus0.FETCH_REQ = 1'b0; bus0.FETCH_ADDR = '0;
    bus0.LS_REQ = 1'b0; bus0.LS_WE = 1'b0; bus0.LS_ADDR = '0; bus0.LS_WDATA = '0;
    bus1.FETCH_REQ = 1'b0; bus1.FETCH_ADDR = '0;
    bus1.LS_REQ = 1'b0; bus1.LS_WE = 1'b0; bus1.LS_ADDR = '0; bus1.LS_WDATA = '0;
  endtask

  task automatic mem_poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_addr = a; bd_data = d; bd_en = 1'b1;
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus0.FETCH_GNT, bus0.FETCH_VALID, bus0.LS_GNT, bus0.LS_VALID,
         bus0.MEM_EN, bus0.MEM_WE, bus0.BUSY} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b%b%b%b%b%b%b expected 0000000", bus0.FETCH_GNT, bus0.FETCH_VALID,
               bus0.LS_GNT, bus0.LS_VALID, bus0.MEM_EN, bus0.MEM_WE, bus0.BUSY);
    end
    checks++;
    if (bus0.FETCH_DATA !== '0 || bus0.LS_RDATA !== '0 || bus0.MEM_ADDR !== '0 || bus0.MEM_WDATA !== '0) begin
      errors++;
      $display("FAIL reset_data: got fd=%h ld=%h ma=%h mw=%h expected all 0", bus0.FETCH_DATA,
               bus0.LS_RDATA, bus0.MEM_ADDR, bus0.MEM_WDATA);
    end
    checks++;
    if ({bus1.BUSY, bus1.MEM_EN, bus1.LS_VALID} !== 3'b0) begin
      errors++;
      $display("FAIL reset_lat3: got busy=%b en=%b v=%b expected 0", bus1.BUSY, bus1.MEM_EN, bus1.LS_VALID);
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    mem_poke(10'h005, 18'h2ABCD);
    bus0.FETCH_ADDR = 10'h005; bus0.FETCH_REQ = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus0.FETCH_GNT, bus0.MEM_EN, bus0.MEM_WE, bus0.LS_GNT, bus0.BUSY} !== 5'b11001) begin
      errors++;
      $display("FAIL fetch_issue: got gnt/en/we/lsgnt/busy=%b%b%b%b%b expected 11001", bus0.FETCH_GNT,
               bus0.MEM_EN, bus0.MEM_WE, bus0.LS_GNT, bus0.BUSY);
    end
    checks++;
    if (bus0.MEM_ADDR !== 10'h005) begin
      errors++; $display("FAIL fetch_addr: got %h expected 005", bus0.MEM_ADDR);
    end
    bus0.FETCH_REQ = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus0.FETCH_VALID, bus0.FETCH_GNT, bus0.MEM_EN, bus0.BUSY} !== 4'b0001) begin
      errors++;
      $display("FAIL fetch_wait: got v/g/en/busy=%b%b%b%b expected 0001", bus0.FETCH_VALID,
               bus0.FETCH_GNT, bus0.MEM_EN, bus0.BUSY);
    end
    @(negedge clk);
    checks++;
    if (bus0.FETCH_VALID !== 1'b1 || bus0.FETCH_DATA !== 18'h2ABCD) begin
      errors++;
      $display("FAIL fetch_resp: got v=%b data=%h expected v=1 data=2abcd", bus0.FETCH_VALID, bus0.FETCH_DATA);
    end
    @(negedge clk);
    checks++;
    if (bus0.FETCH_VALID !== 1'b0 || bus0.BUSY !== 1'b0 || bus0.FETCH_DATA !== 18'h2ABCD) begin
      errors++;
      $display("FAIL fetch_after: got v=%b busy=%b data=%h expected 0 0 2abcd", bus0.FETCH_VALID,
               bus0.BUSY, bus0.FETCH_DATA);
    end
  endtask

  task automatic test_store();
    bus0.LS_REQ = 1'b1; bus0.LS_WE = 1'b1; bus0.LS_ADDR = 10'h3FF; bus0.LS_WDATA = 18'h15555;
    @(negedge clk);
    checks++;
    if ({bus0.LS_GNT, bus0.FETCH_GNT, bus0.MEM_EN, bus0.MEM_WE} !== 4'b1011 ||
        bus0.MEM_ADDR !== 10'h3FF || bus0.MEM_WDATA !== 18'h15555) begin
      errors++;
      $display("FAIL store_issue: got g=%b fg=%b en=%b we=%b a=%h wd=%h expected 1 0 1 1 3ff 15555",
               bus0.LS_GNT, bus0.FETCH_GNT, bus0.MEM_EN, bus0.MEM_WE, bus0.MEM_ADDR, bus0.MEM_WDATA);
    end
    bus0.LS_REQ = 1'b0;
    @(negedge clk);
    checks++;
    if (bus0.LS_VALID !== 1'b0 || bus0.MEM_WE !== 1'b0 || bus0.MEM_WDATA !== 18'h15555) begin
      errors++;
      $display("FAIL store_wait: got v=%b we=%b wd=%h expected 0 0 15555", bus0.LS_VALID,
               bus0.MEM_WE, bus0.MEM_WDATA);
    end
    @(negedge clk);
    checks++;
    if (bus0.LS_VALID !== 1'b1 || bus0.LS_RDATA !== 18'h0) begin
      errors++;
      $display("FAIL store_resp: got v=%b rdata=%h expected 1 00000", bus0.LS_VALID, bus0.LS_RDATA);
    end
    // Back-to-back load of the stored word, requested during RESPOND.
    bus0.LS_REQ = 1'b1; bus0.LS_WE = 1'b0;
    @(negedge clk);
    checks++;
    if (bus0.LS_GNT !== 1'b1 || bus0.MEM_WE !== 1'b0 || bus0.MEM_ADDR !== 10'h3FF) begin
      errors++;
      $display("FAIL load_b2b_issue: got g=%b we=%b a=%h expected 1 0 3ff", bus0.LS_GNT, bus0.MEM_WE, bus0.MEM_ADDR);
    end
    bus0.LS_REQ = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus0.LS_VALID !== 1'b1 || bus0.LS_RDATA !== 18'h15555) begin
      errors++;
      $display("FAIL load_b2b_resp: got v=%b rdata=%h expected 1 15555", bus0.LS_VALID, bus0.LS_RDATA);
    end
    @(negedge clk);
  endtask

  task automatic test_priority();
    int exp_ls [6] = '{1, 1, 0, 1, 1, 0};
    int n = 0;
    int last = 0;
    bus0.FETCH_REQ = 1'b1; bus0.FETCH_ADDR = 10'h005;
    bus0.LS_REQ = 1'b1; bus0.LS_WE = 1'b0; bus0.LS_ADDR = 10'h3FF;
    for (int c = 1; c <= 40 && n < 6; c++) begin
      @(negedge clk);
      if (bus0.FETCH_GNT || bus0.LS_GNT) begin
        checks++;
        if ({bus0.FETCH_GNT, bus0.LS_GNT} !== ((exp_ls[n] == 1) ? 2'b01 : 2'b10)) begin
          errors++;
          $display("FAIL prio_order grant %0d: got fgnt/lsgnt=%b%b expected ls=%0d", n,
                   bus0.FETCH_GNT, bus0.LS_GNT, exp_ls[n]);
        end
        checks++;
        if (c - last !== 3 && n > 0) begin
          errors++;
          $display("FAIL prio_spacing grant %0d: got %0d cycles expected 3", n, c - last);
        end else if (n == 0 && c !== 1) begin
          errors++;
          $display("FAIL prio_first: got cycle %0d expected 1", c);
        end
        last = c;
        n++;
      end
    end
    checks++;
    if (n !== 6) begin
      errors++; $display("FAIL prio_timeout: got %0d grants expected 6", n);
    end
    bus0.FETCH_REQ = 1'b0; bus0.LS_REQ = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_latency3();
    bus1.LS_REQ = 1'b1; bus1.LS_WE = 1'b0; bus1.LS_ADDR = 10'h010;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++;
      if ({bus1.LS_GNT, bus1.LS_VALID, bus1.BUSY} !== {c == 1, c == 5, c <= 5}) begin
        errors++;
        $display("FAIL lat3_cycle%0d: got gnt/valid/busy=%b%b%b expected %b%b%b", c, bus1.LS_GNT,
                 bus1.LS_VALID, bus1.BUSY, c == 1, c == 5, c <= 5);
      end
      if (c == 1) bus1.LS_REQ = 1'b0;
      if (c == 5) begin
        checks++;
        if (bus1.LS_RDATA !== pat1(10'h010)) begin
          errors++; $display("FAIL lat3_data: got %h expected %h", bus1.LS_RDATA, pat1(10'h010));
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    mem_poke(10'h020, 18'h1F00F);
    bus0.FETCH_REQ = 1'b1; bus0.FETCH_ADDR = 10'h020;
    @(negedge clk);
    bus0.FETCH_REQ = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus0.FETCH_GNT, bus0.FETCH_VALID, bus0.MEM_EN, bus0.MEM_WE, bus0.BUSY} !== 5'b0 ||
        bus0.FETCH_DATA !== '0 || bus0.MEM_ADDR !== '0) begin
      errors++;
      $display("FAIL abort_async: got g/v/en/we/busy=%b%b%b%b%b fd=%h ma=%h expected zeros", bus0.FETCH_GNT,
               bus0.FETCH_VALID, bus0.MEM_EN, bus0.MEM_WE, bus0.BUSY, bus0.FETCH_DATA, bus0.MEM_ADDR);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (bus0.FETCH_VALID !== 1'b0 || bus0.BUSY !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet: got valid=%b busy=%b expected 0 0", bus0.FETCH_VALID, bus0.BUSY);
      end
    end
    bus0.FETCH_REQ = 1'b1;
    @(negedge clk);
    checks++;
    if (bus0.FETCH_GNT !== 1'b1) begin
      errors++; $display("FAIL abort_regrant: got gnt=%b expected 1", bus0.FETCH_GNT);
    end
    bus0.FETCH_REQ = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus0.FETCH_VALID !== 1'b1 || bus0.FETCH_DATA !== 18'h1F00F) begin
      errors++;
      $display("FAIL abort_reresp: got v=%b data=%h expected 1 1f00f", bus0.FETCH_VALID, bus0.FETCH_DATA);
    end
    @(negedge clk);
  endtask

  task automatic test_withdraw();
    @(negedge clk);
    bus0.FETCH_ADDR = 10'h007; bus0.FETCH_REQ = 1'b1;
    #2 bus0.FETCH_REQ = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (bus0.FETCH_GNT !== 1'b0 || bus0.BUSY !== 1'b0) begin
        errors++;
        $display("FAIL withdraw: got gnt=%b busy=%b expected 0 0", bus0.FETCH_GNT, bus0.BUSY);
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] shadow [0:15];
    bit            f_act = 0, l_act = 0, l_we = 0;
    logic [AW-1:0] f_addr = '0, l_addr = '0;
    logic [DW-1:0] l_wdata = '0;
    bit            exp_issue = 0, exp_fw = 0, arb_freq = 0, pending = 0;
    bit            pend_fetch = 0, pend_we = 0, exp_v, arb_now;
    logic [AW-1:0] win_addr = '0;
    logic [DW-1:0] win_wdata = '0, pend_rd = '0, fdata_m = '0, ldata_m = '0;
    bit            win_we = 0;
    int            streak_m = 0, pend_cycle = 0;

    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 16; a++) begin
      shadow[a] = DW'($urandom);
      mem_poke(AW'(a), shadow[a]);
    end

    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      checks++;
      if (bus0.MEM_EN !== exp_issue || (bus0.FETCH_GNT | bus0.LS_GNT) !== exp_issue) begin
        errors++;
        $display("FAIL rnd_issue t=%0d: got en=%b gnt=%b%b expected %b", t, bus0.MEM_EN,
                 bus0.FETCH_GNT, bus0.LS_GNT, exp_issue);
      end else if (exp_issue) begin
        checks++;
        if ({bus0.FETCH_GNT, bus0.LS_GNT} !== (exp_fw ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL rnd_winner t=%0d: got fgnt/lsgnt=%b%b expected fetch=%b", t,
                   bus0.FETCH_GNT, bus0.LS_GNT, exp_fw);
        end
        checks++;
        if (bus0.MEM_ADDR !== win_addr || bus0.MEM_WE !== win_we ||
            (win_we && bus0.MEM_WDATA !== win_wdata)) begin
          errors++;
          $display("FAIL rnd_fields t=%0d: got a=%h we=%b wd=%h expected a=%h we=%b wd=%h", t,
                   bus0.MEM_ADDR, bus0.MEM_WE, bus0.MEM_WDATA, win_addr, win_we, win_wdata);
        end
        pending = 1; pend_cycle = t; pend_fetch = exp_fw; pend_we = win_we;
        pend_rd = shadow[win_addr[3:0]];
        if (win_we) shadow[win_addr[3:0]] = win_wdata;
        if (exp_fw || !arb_freq) streak_m = 0;
        else if (streak_m < MAXS) streak_m++;
        if (exp_fw) f_act = 0; else l_act = 0;
      end

      exp_v = pending && (t == pend_cycle + 2);
      checks++;
      if ({bus0.FETCH_VALID, bus0.LS_VALID} !== {exp_v && pend_fetch, exp_v && !pend_fetch}) begin
        errors++;
        $display("FAIL rnd_valid t=%0d: got fv/lv=%b%b expected %b%b", t, bus0.FETCH_VALID,
                 bus0.LS_VALID, exp_v && pend_fetch, exp_v && !pend_fetch);
      end
      if (exp_v) begin
        if (pend_fetch) fdata_m = pend_rd;
        else if (!pend_we) ldata_m = pend_rd;
        checks++;
        if (bus0.FETCH_DATA !== fdata_m || bus0.LS_RDATA !== ldata_m) begin
          errors++;
          $display("FAIL rnd_data t=%0d: got fd=%h ld=%h expected fd=%h ld=%h", t,
                   bus0.FETCH_DATA, bus0.LS_RDATA, fdata_m, ldata_m);
        end
      end
      checks++;
      if (bus0.BUSY !== pending) begin
        errors++; $display("FAIL rnd_busy t=%0d: got %b expected %b", t, bus0.BUSY, pending);
      end
      arb_now = !pending || exp_v;
      if (exp_v) pending = 0;

      if (!f_act && $urandom_range(0, 2) == 0) begin
        f_act = 1; f_addr = AW'($urandom_range(0, 15));
      end else if (f_act && $urandom_range(0, 19) == 0) f_act = 0;
      if (!l_act && $urandom_range(0, 2) == 0) begin
        l_act = 1; l_we = 1'($urandom_range(0, 1));
        l_addr = AW'($urandom_range(0, 15)); l_wdata = DW'($urandom);
      end else if (l_act && $urandom_range(0, 19) == 0) l_act = 0;
      bus0.FETCH_REQ = f_act; bus0.FETCH_ADDR = f_addr;
      bus0.LS_REQ = l_act; bus0.LS_WE = l_we; bus0.LS_ADDR = l_addr; bus0.LS_WDATA = l_wdata;

      exp_issue = arb_now && (f_act || l_act);
      exp_fw    = f_act && (!l_act || streak_m == MAXS);
      arb_freq  = f_act;
      win_addr  = exp_fw ? f_addr : l_addr;
      win_we    = exp_fw ? 1'b0 : l_we;
      win_wdata = l_wdata;
    end
    idle_inputs();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch();
    test_store();
    test_priority();
    test_latency3();
    test_reset_abort();
    test_withdraw();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
